// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: per-button 2-FF synchronizer, counter debounce
// FSM, registered clean level and one-cycle press strobe.
module btn_debounce_pulse #(
    parameter int N_BTN      = 3,
    parameter int N_CNT      = 20,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_BTN-1:0] o_btn_pulse,
    output logic [N_BTN-1:0] o_btn_level
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HELD,
        REL
    } state_t;

    localparam logic [N_CNT-1:0] CNT_LAST = N_CNT'(DEB_CYCLES - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        state_t           state;
        state_t           state_nx;
        logic [N_CNT-1:0] cnt;
        logic [N_CNT-1:0] cnt_nx;
        logic             pulse_q;
        logic             pulse_nx;
        logic             level_q;
        logic             level_nx;
        logic             s;

        assign s = sync2[g];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state   <= IDLE;
                cnt     <= '0;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
            end else begin
                state   <= state_nx;
                cnt     <= cnt_nx;
                pulse_q <= pulse_nx;
                level_q <= level_nx;
            end
        end

        // ARM/REL count consecutive agreeing samples; any opposite
        // sample abandons the transition and restarts from the stable state.
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            pulse_nx = 1'b0;
            level_nx = level_q;
            unique case (state)
                IDLE: begin
                    if (s) begin
                        state_nx = ARM;
                        cnt_nx   = '0;
                    end
                end
                ARM: begin
                    if (!s) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = HELD;
                        pulse_nx = 1'b1;
                        level_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_nx = REL;
                        cnt_nx   = '0;
                    end
                end
                REL: begin
                    if (s) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = IDLE;
                        level_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    level_nx = 1'b0;
                end
            endcase
        end

        assign o_btn_pulse[g] = pulse_q;
        assign o_btn_level[g] = level_q;
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with DEB_CYCLES=4, N_CNT=4, N_BTN=3.
// Vector i drives raw before edge i and checks outputs just after edge i.
module tb_btn_debounce_pulse;

    logic       i_clk;
    logic       i_rst_n;
    logic [2:0] i_btn_raw;
    logic [2:0] o_btn_pulse;
    logic [2:0] o_btn_level;

    int checks;
    int errors;

    typedef struct {
        logic [2:0] raw;
        logic [2:0] pulse;
        logic [2:0] level;
    } vec_t;

    vec_t vecs[$];

    btn_debounce_pulse #(
        .N_BTN     (3),
        .N_CNT     (4),
        .DEB_CYCLES(4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_btn_raw  (i_btn_raw),
        .o_btn_pulse(o_btn_pulse),
        .o_btn_level(o_btn_level)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int idx,
                       input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %b expected %b", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic [2:0] r, input logic [2:0] p,
                       input logic [2:0] l);
        vec_t v;
        v.raw   = r;
        v.pulse = p;
        v.level = l;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic apply_vecs(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            i_btn_raw = vecs[i].raw;
            @(posedge i_clk);
            #1;
            chk({name, "_pulse"}, i, o_btn_pulse, vecs[i].pulse);
            chk({name, "_level"}, i, o_btn_level, vecs[i].level);
            @(negedge i_clk);
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        i_btn_raw = 3'b000;
        i_rst_n   = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        i_btn_raw = 3'b000;
        i_rst_n   = 1'b0;
        #2;
        chk("reset_pulse", 0, o_btn_pulse, 3'b000);
        chk("reset_level", 0, o_btn_level, 3'b000);

        // Clean press on btn0, held 20 edges, then released.
        do_reset();
        for (int i = 0; i < 30; i++)
            add((i < 20) ? 3'b001 : 3'b000,
                (i == 6) ? 3'b001 : 3'b000,
                (i >= 6 && i < 26) ? 3'b001 : 3'b000);
        apply_vecs("clean");

        // Bounce on btn1: last rising sample at edge 4 -> pulse at edge 10.
        do_reset();
        for (int i = 0; i < 16; i++)
            add((i == 1 || i == 3) ? 3'b000 : 3'b010,
                (i == 10) ? 3'b010 : 3'b000,
                (i >= 10) ? 3'b010 : 3'b000);
        apply_vecs("bounce");

        // Three-cycle glitch on btn2 never reaches the outputs.
        do_reset();
        for (int i = 0; i < 15; i++)
            add((i < 3) ? 3'b100 : 3'b000, 3'b000, 3'b000);
        apply_vecs("glitch");

        // Two-sample release bounce while held: no drop, no second pulse.
        do_reset();
        for (int i = 0; i < 25; i++)
            add((i == 10 || i == 11) ? 3'b000 : 3'b001,
                (i == 6) ? 3'b001 : 3'b000,
                (i >= 6) ? 3'b001 : 3'b000);
        apply_vecs("relbounce");

        // Simultaneous press on btn0 and btn2.
        do_reset();
        for (int i = 0; i < 10; i++)
            add(3'b101,
                (i == 6) ? 3'b101 : 3'b000,
                (i >= 6) ? 3'b101 : 3'b000);
        apply_vecs("simul");

        // btn1 held, btn0 in ARM with cnt=2 after edge 14, then async reset.
        do_reset();
        for (int i = 0; i < 15; i++)
            add((i >= 10) ? 3'b011 : 3'b010,
                (i == 6) ? 3'b010 : 3'b000,
                (i >= 6) ? 3'b010 : 3'b000);
        apply_vecs("prerst");
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_pulse", 0, o_btn_pulse, 3'b000);
        chk("async_rst_level", 0, o_btn_level, 3'b000);
        @(posedge i_clk);
        #1;
        chk("hold_rst_pulse", 0, o_btn_pulse, 3'b000);
        chk("hold_rst_level", 0, o_btn_level, 3'b000);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        // Buttons still held at release count as fresh presses.
        for (int i = 0; i < 10; i++)
            add(3'b011,
                (i == 6) ? 3'b011 : 3'b000,
                (i >= 6) ? 3'b011 : 3'b000);
        apply_vecs("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
